pc_next_unit: RTL

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter sequencer for the fetch stage.
// Computes the next PC from branch/jump/redirect state; optional RAS.
//
// Purpose:
//   Holds the architectural fetch PC and selects its next value from
//   sequential flow, taken branches, JAL, JALR, external redirects and
//   the misaligned-target trap vector. Optionally tracks call/return
//   addresses in a small circular return-address stack.
//
// Configuration:
//   PC_NEXT_RAS_EN  defined   -> return-address stack is built.
//                   undefined -> no RAS storage; ras_top=0, ras_empty=1.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stall             hold pc and RAS this cycle
//   redirect_valid    load redirect_pc (wins over stall)
//   redirect_pc       redirect target
//   jump              0..5 cond. branch, 6 JAL, 7 JALR
//   branch, zero      branch instruction / condition true
//   imm               branch/JAL offset
//   alu_result        JALR target (rs1+imm)
//   rd_link, rs1_link rd / rs1 is a link register (x1/x5)
//   pc                registered current PC
//   pc_next           value pc loads on the next unstalled edge
//   misalign_err      one-cycle pulse on a trapped target
//   ras_top           predicted return address (0 when empty)
//   ras_empty         RAS holds no entries
module pc_next_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [2:0]      jump,
   input  logic            branch,
   input  logic            zero,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_result,
   input  logic            rd_link,
   input  logic            rs1_link,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            misalign_err,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            misalign_err_q;
   logic            misalign_err_d;

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] rel_tgt;
   logic [XLEN-1:0] jr_tgt;
   logic [XLEN-1:0] raw_tgt;
   logic            taken;
   logic            is_jal;
   logic            is_jalr;
   logic            non_seq;
   logic            trap;
   logic            advance;

   // JALR target bit 0 is architecturally discarded.
   logic unused_alu_b0;
   assign unused_alu_b0 = alu_result[0];

   always_comb begin
      seq_pc  = pc_q + XLEN'(4);
      rel_tgt = pc_q + imm;
      jr_tgt  = {alu_result[XLEN-1:1], 1'b0};
      taken   = (jump <= 3'd5) & branch & zero;
      is_jal  = (jump == 3'd6);
      is_jalr = (jump == 3'd7);
      non_seq = taken | is_jal | is_jalr;

      raw_tgt = seq_pc;
      unique case (1'b1)
         taken,
         is_jal:  raw_tgt = rel_tgt;
         is_jalr: raw_tgt = jr_tgt;
         default: ;
      endcase

      // Bit 0 is always clear on the jump paths, so bit 1 alone
      // flags a non-word-aligned control-flow target.
      trap    = non_seq & raw_tgt[1];
      advance = ~redirect_valid & ~stall;

      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (trap) begin
         pc_d = TRAP_VECTOR;
      end else begin
         pc_d = raw_tgt;
      end

      misalign_err_d = advance & trap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_VECTOR;
         misalign_err_q <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign pc           = pc_q;
   assign pc_next      = pc_d;
   assign misalign_err = misalign_err_q;

`ifdef PC_NEXT_RAS_EN

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [XLEN-1:0] ras_d [RAS_DEPTH];
   logic [PW-1:0]   sp_q;
   logic [PW-1:0]   sp_d;
   logic [PW-1:0]   sp_inc;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            push;
   logic            pop;
   logic            swap;

   // sp_q indexes the newest entry; the buffer is circular so a push
   // into a full stack silently overwrites the oldest slot.
   always_comb begin
      push   = advance & (is_jal | is_jalr) & rd_link;
      pop    = advance & is_jalr & rs1_link & ~rd_link;
      swap   = push & is_jalr & rs1_link & (cnt_q != '0);
      sp_inc = sp_q + 1'b1;

      ras_d = ras_q;
      sp_d  = sp_q;
      cnt_d = cnt_q;

      if (swap) begin
         ras_d[sp_q] = seq_pc;
      end else if (push) begin
         sp_d         = sp_inc;
         ras_d[sp_inc] = seq_pc;
         if (cnt_q != CW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop && (cnt_q != '0)) begin
         sp_d  = sp_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= ras_d[i];
         end
      end
   end

   assign ras_empty = (cnt_q == '0);
   assign ras_top   = ras_empty ? '0 : ras_q[sp_q];

`else

   logic unused_ras;
   assign unused_ras = rd_link ^ rs1_link;

   assign ras_top   = '0;
   assign ras_empty = 1'b1;

`endif

endmodule
